// File: rtl/cascade_digit_counter.sv
// cascade_digit_counter: NUM_DIG cascaded modulo-MOD digit counters sharing one clock.
// Features: enable, up/down, synchronous clear, parallel load with per-digit clamp,
// terminal-count and zero flags.
// Optional macro CASCADE_DIGIT_COUNTER_SATURATE_EN: saturate at the chain limits
// instead of wrapping.
module cascade_digit_counter #(
    parameter int unsigned DIGIT_W = 4,
    parameter int unsigned MOD     = 10,
    parameter int unsigned NUM_DIG = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       up_dn,
    input  logic                       clr,
    input  logic                       load,
    input  logic [NUM_DIG*DIGIT_W-1:0] load_val,
    output logic [NUM_DIG*DIGIT_W-1:0] cnt,
    output logic                       tc,
    output logic                       zero
);

    localparam logic [DIGIT_W-1:0] MAX_DIG = DIGIT_W'(MOD - 1);

    logic [NUM_DIG*DIGIT_W-1:0] cnt_q, cnt_d;
    logic [NUM_DIG-1:0]         dig_max, dig_zero;
    logic                       all_max, all_zero;
    logic                       at_limit;

    // Per-digit limit detection, shared by the cascade and the flags.
    always_comb begin
        dig_max  = '0;
        dig_zero = '0;
        for (int i = 0; i < int'(NUM_DIG); i++) begin
            dig_max[i]  = (cnt_q[i*DIGIT_W +: DIGIT_W] == MAX_DIG);
            dig_zero[i] = (cnt_q[i*DIGIT_W +: DIGIT_W] == '0);
        end
    end

    assign all_max  = &dig_max;
    assign all_zero = &dig_zero;
    // Whole chain sits at the end it is heading towards.
    assign at_limit = up_dn ? all_max : all_zero;

    // Next-state: clr > load > en; all digits step on the same edge.
    always_comb begin
        logic              step;
        logic [DIGIT_W-1:0] dig;
        logic [DIGIT_W-1:0] ld;
        cnt_d = cnt_q;
        step  = 1'b0;
        dig   = '0;
        ld    = '0;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            for (int i = 0; i < int'(NUM_DIG); i++) begin
                ld = load_val[i*DIGIT_W +: DIGIT_W];
                cnt_d[i*DIGIT_W +: DIGIT_W] = (32'(ld) >= MOD) ? MAX_DIG : ld;
            end
        end else if (en) begin
`ifdef CASCADE_DIGIT_COUNTER_SATURATE_EN
            step = !at_limit;
`else
            step = 1'b1;
`endif
            for (int i = 0; i < int'(NUM_DIG); i++) begin
                dig = cnt_q[i*DIGIT_W +: DIGIT_W];
                if (step) begin
                    if (up_dn) begin
                        cnt_d[i*DIGIT_W +: DIGIT_W] = dig_max[i] ? '0 : dig + 1'b1;
                    end else begin
                        cnt_d[i*DIGIT_W +: DIGIT_W] = dig_zero[i] ? MAX_DIG : dig - 1'b1;
                    end
                end
                // Carry/borrow moves up only past a digit that wrapped.
                step = step & (up_dn ? dig_max[i] : dig_zero[i]);
            end
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Flags; tc is suppressed while reset is held so en cannot raise it.
    always_comb begin
        tc   = reset & en & !clr & !load & at_limit;
        zero = all_zero;
    end

    assign cnt = cnt_q;

endmodule

// File: doc/cascade_digit_counter.md
Name: cascade_digit_counter

Overview:
- Parametrised successor to the team's fixed 4-bit counter.
- Chain of NUM_DIG modulo-MOD digit counters; each digit carries into or borrows from the next more-significant digit.
- Adds enable, up/down direction, synchronous clear, parallel load, and a terminal-count flag.
- Used as a decimal display/event counter feeding seven-segment and timer blocks. Default configuration is 2 BCD digits (00..99).

Parameters:
- DIGIT_W, 4: bits per digit; must satisfy 2^DIGIT_W >= MOD.
- MOD, 10: modulus of each digit; legal range 2..2^DIGIT_W.
- NUM_DIG, 2: number of cascaded digits; legal range 1..8.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  count enable; one step per clock when high.
- up_dn  input  1  direction: 1 = up, 0 = down.
- clr  input  1  synchronous clear to all-zero.
- load  input  1  synchronous parallel load.
- load_val  input  NUM_DIG*DIGIT_W  load value; digit 0 (least significant) is in bits [DIGIT_W-1:0].
- cnt  output  NUM_DIG*DIGIT_W  registered count, packed with the same layout as load_val.
- tc  output  1  terminal count: next enabled edge wraps the whole chain.
- zero  output  1  high when every digit is 0.

Behaviour:
- Reset: reset low asynchronously forces cnt = 0. Consequently tc = 0 (en is ignored in that condition) and zero = 1. Counting resumes on the first rising clk edge after reset goes high.
- Priority at each rising edge: clr > load > en. With none of them asserted, cnt holds.
- clr: cnt <= 0 on the next edge.
- load: each digit i <= load_val digit i. A digit value >= MOD is clamped to MOD-1, per digit.
- en with up_dn = 1:
  - digit 0 increments.
  - Digit i increments only when digits 0..i-1 are all MOD-1.
  - A digit at MOD-1 that increments wraps to 0.
- en with up_dn = 0:
  - digit 0 decrements.
  - Digit i decrements only when digits 0..i-1 are all 0.
  - A digit at 0 that decrements wraps to MOD-1.
- Latency: a new cnt value is visible 1 cycle after the controlling edge. All digits update on the same edge (synchronous cascade, no ripple clocks).
- tc is combinational from registered cnt and the current inputs:
  - up: en & up_dn & all digits == MOD-1.
  - down: en & !up_dn & all digits == 0.
  - tc is forced low when clr or load is high.
- zero is combinational: all digits == 0. It is independent of en.
- Whole-chain wrap (no optional feature):
  - up from max (all MOD-1) goes to all 0.
  - down from all 0 goes to max.
- Direction change takes effect on the next edge with no extra cycle; up_dn toggling every cycle is legal.
- Reset asserted mid-count clears immediately. A load or clr coincident with reset deassertion is ignored until the next edge.

Optional Feature:
- Macro: CASCADE_DIGIT_COUNTER_SATURATE_EN
- Defined:
  - Counting up at all MOD-1 holds; counting down at all 0 holds.
  - tc is still asserted in those states to flag the limit. Holding there with en high keeps tc high every cycle.
- Undefined: the chain wraps as described under Behaviour. Default build is undefined.

Test Plan:
- Reset and count up: reset low then high; en=1, up_dn=1 for 12 cycles -> cnt = 0x12 (digits 1,2), zero=0. Digit 0 wraps 9->0 while digit 1 goes 0->1 on the same edge.
- Wrap up: load 0x98, en=1, up_dn=1 -> 0x99 with tc=1, then 0x00 with zero=1. With SATURATE_EN defined, cnt stays at 0x99 and tc stays 1.
- Count down and borrow: load 0x10, up_dn=0, en=1 -> 0x09, then 0x08. From 0x00, one step down -> 0x99 (wrap build).
- Priority: clr=1, load=1 with load_val=0x55 and en=1 on the same edge -> cnt = 0x00. Next edge with load=1 only -> cnt = 0x55.
- Load clamp: load_val = 0xFC -> cnt = 0x99. Enable hold: en=0 for 5 cycles -> cnt unchanged, tc=0.
- Async reset mid-count: at cnt = 0x47, pull reset low between clock edges -> cnt = 0x00 immediately, before the next clk edge.
